channel_dir_ctrl: RTL and testbench
===================================

CHANNEL_DIR_CTRL -- requirements
Module: channel_dir_ctrl

Interface
REQ-001 Parameter TURN_CYC, default 1: number of dead cycles, with both grants low, inserted on every direction reversal; legal range 1..7.
REQ-002 Parameter IDLE_TO, default 8: number of consecutive no-transfer owner cycles after which a pending opposite request may take the channel; legal range 2..255.
REQ-003 Parameter RESET_DIR, default 0: value of dir after reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req_a  input  1  end A has a packet queued for this bidirectional channel.
REQ-007 valid_a  input  1  end A presents a flit this cycle.
REQ-008 tail_a  input  1  the flit presented by A is the last flit of its packet; qualified by valid_a.
REQ-009 full_a  input  1  A's input buffer for this channel is full.
REQ-010 req_b, valid_b, tail_b, full_b  input  1 each  same meaning for end B.
REQ-011 gnt_a  output  1  registered; A may drive the channel (tristate enable).
REQ-012 gnt_b  output  1  registered; B may drive the channel (tristate enable).
REQ-013 xfer_a  output  1  combinational; equals gnt_a & valid_a & !full_b; a flit from A is accepted this cycle.
REQ-014 xfer_b  output  1  combinational; equals gnt_b & valid_b & !full_a.
REQ-015 dir  output  1  registered; 0 = A to B, 1 = B to A.
REQ-016 state  output  2  registered; 0 IDLE, 1 OWN_A, 2 OWN_B, 3 TURN.

Function
REQ-017 gnt_a = (state==OWN_A) and gnt_b = (state==OWN_B); gnt_a and gnt_b shall never both be 1.
REQ-018 in_pkt (internal) shall be set on xfer with tail low and cleared on xfer with tail high; it applies to the current owner only.
REQ-019 The owner boundary, bnd, shall be (xfer & tail) | (!in_pkt & !xfer); no ownership change is allowed unless bnd is 1.
REQ-020 idle_cnt (8 bit) shall increment on each owner cycle with no xfer, saturate at IDLE_TO, and clear on xfer or on any state change.
REQ-021 IDLE, single request: request from side X with X matching dir -> OWN_X next cycle; X differing from dir -> TURN.
REQ-022 IDLE, both requests: the side that is not last_owner wins, then the REQ-021 rules apply.
REQ-023 OWN_X, bnd=1 and opposite request high and (xfer&tail | !req_X | idle_cnt==IDLE_TO) -> TURN toward the opposite side.
REQ-024 OWN_X, bnd=1 otherwise: req_X high -> stay in OWN_X; req_X low -> IDLE.
REQ-025 OWN_X, bnd=0: stay in OWN_X; a packet is never split across owners.
REQ-026 On entry to TURN: dir shall toggle and turn_cnt shall load TURN_CYC-1.
REQ-027 TURN: decrement turn_cnt each cycle; at 0, go to the owner given by dir.
REQ-028 TURN shall complete even if the target's request drops; the resulting owner then falls to IDLE at its first bnd.
REQ-029 last_owner shall update on every entry to OWN_A or OWN_B.
REQ-030 Latency: an uncontested request from IDLE with matching dir is granted on the next edge; with non-matching dir it is granted after 1+TURN_CYC edges.
REQ-031 Simultaneous tail from the owner and a new request from the other side: switch (REQ-023).
REQ-032 A full receiver stalls xfer only; it does not count as a boundary.

Reset
REQ-033 On rst=1 at a clock edge: state=IDLE, gnt_a=gnt_b=0, dir=RESET_DIR, last_owner=B, in_pkt=0, idle_cnt=0, turn_cnt=0.
REQ-034 Reset asserted mid-packet or in TURN shall abort immediately, with no drain.
REQ-035 The block shall act on requests from the first edge after rst deasserts.

Verification
REQ-036 Reset with req_a=1, dir=0 -> gnt_a=1 on the first edge after reset; send a 3-flit packet -> xfer_a exactly 3 cycles; drop req_a -> IDLE.
REQ-037 In OWN_A mid-packet, raise req_b -> gnt_a stays 1 until tail_a is transferred; then TURN for TURN_CYC cycles with both grants 0; then gnt_b=1 and dir=1.
REQ-038 In IDLE, req_a and req_b raised in the same cycle, last_owner=A -> B is granted (via TURN when dir=0); repeat -> grants alternate.
REQ-039 OWN_A with req_a held high, valid_a=0, in_pkt=0, req_b=1 -> switch to TURN after IDLE_TO idle cycles (8 with default).
REQ-040 OWN_A with full_b=1 for 5 cycles mid-packet -> xfer_a=0, ownership held, no switch.
REQ-041 rst asserted during TURN -> IDLE, grants 0, dir=RESET_DIR on the next edge.

Source files
------------

// File: rtl/channel_dir_ctrl.sv
// channel_dir_ctrl
// Direction controller for a bidirectional (tristate) channel shared by
// ends A and B. It grants the channel to one end at a time and switches
// ownership only at packet boundaries. Every reversal passes through a
// dead-time window with both grants low.
//
// Ports
//   clk               rising-edge clock
//   rst               synchronous active-high reset
//   req_a / req_b     end has a packet queued for the channel
//   valid_a / valid_b end presents a flit this cycle
//   tail_a / tail_b   presented flit is the last of its packet
//   full_a / full_b   end's input buffer is full (stalls the far side)
//   gnt_a / gnt_b     registered drive enables, mutually exclusive
//   xfer_a / xfer_b   flit accepted this cycle (combinational)
//   dir               registered direction, 0 = A to B, 1 = B to A
//   state             registered FSM state
//
// state  | meaning
// IDLE   | nobody owns the channel
// OWN_A  | A drives the channel, dir = 0
// OWN_B  | B drives the channel, dir = 1
// TURN   | dead time after a reversal, both grants low
module channel_dir_ctrl #(
   parameter int unsigned TURN_CYC  = 1,
   parameter int unsigned IDLE_TO   = 8,
   parameter logic        RESET_DIR = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_a,
   input  logic       valid_a,
   input  logic       tail_a,
   input  logic       full_a,
   input  logic       req_b,
   input  logic       valid_b,
   input  logic       tail_b,
   input  logic       full_b,
   output logic       gnt_a,
   output logic       gnt_b,
   output logic       xfer_a,
   output logic       xfer_b,
   output logic       dir,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_OWN_A = 2'd1,
      S_OWN_B = 2'd2,
      S_TURN  = 2'd3
   } state_e;

   localparam logic [7:0] IDLE_TO_C = 8'(IDLE_TO);
   localparam logic [2:0] TURN_LD   = 3'(TURN_CYC - 1);

   state_e     state_q, state_d;
   logic       gnt_a_q, gnt_b_q;
   logic       dir_q, dir_d;
   logic       last_q, last_d;       // 0 = A, 1 = B
   logic       in_pkt_q, in_pkt_d;
   logic [7:0] idle_cnt_q, idle_cnt_d;
   logic [2:0] turn_cnt_q, turn_cnt_d;

   logic own_a, own_b, own, xfer, tail, req_own, req_opp, bnd, want_b;

   assign xfer_a = gnt_a_q & valid_a & ~full_b;
   assign xfer_b = gnt_b_q & valid_b & ~full_a;

   always_comb begin
      own_a   = (state_q == S_OWN_A);
      own_b   = (state_q == S_OWN_B);
      own     = own_a | own_b;
      // Only the owner's grant can be high, so the OR is the owner's xfer.
      xfer    = xfer_a | xfer_b;
      tail    = own_a ? tail_a : tail_b;
      req_own = own_a ? req_a : req_b;
      req_opp = own_a ? req_b : req_a;
      // A stalled flit (full receiver) is neither an xfer nor a boundary
      // while a packet is open.
      bnd     = (xfer & tail) | (~in_pkt_q & ~xfer);
      // Contention in IDLE goes to the end that did not own last.
      want_b  = (req_a & req_b) ? ~last_q : req_b;
   end

   always_comb begin
      state_d    = state_q;
      dir_d      = dir_q;
      turn_cnt_d = turn_cnt_q;
      last_d     = last_q;
      in_pkt_d   = in_pkt_q;
      idle_cnt_d = idle_cnt_q;

      unique case (state_q)
         S_IDLE: begin
            if (req_a | req_b) begin
               if (want_b == dir_q) begin
                  state_d = want_b ? S_OWN_B : S_OWN_A;
               end else begin
                  state_d    = S_TURN;
                  dir_d      = ~dir_q;
                  turn_cnt_d = TURN_LD;
               end
            end
         end
         S_OWN_A, S_OWN_B: begin
            if (bnd) begin
               if (req_opp && ((xfer & tail) || !req_own || idle_cnt_q == IDLE_TO_C)) begin
                  state_d    = S_TURN;
                  dir_d      = ~dir_q;
                  turn_cnt_d = TURN_LD;
               end else if (!req_own) begin
                  state_d = S_IDLE;
               end
            end
         end
         S_TURN: begin
            // Completes regardless of the target's request; a target that
            // dropped its request falls back to IDLE at its first boundary.
            if (turn_cnt_q == 3'd0) begin
               state_d = dir_q ? S_OWN_B : S_OWN_A;
            end else begin
               turn_cnt_d = turn_cnt_q - 3'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (state_d == S_OWN_A && state_q != S_OWN_A) last_d = 1'b0;
      if (state_d == S_OWN_B && state_q != S_OWN_B) last_d = 1'b1;

      if (xfer) in_pkt_d = ~tail;

      if (state_d != state_q || xfer) begin
         idle_cnt_d = 8'd0;
      end else if (own && idle_cnt_q != IDLE_TO_C) begin
         idle_cnt_d = idle_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         gnt_a_q    <= 1'b0;
         gnt_b_q    <= 1'b0;
         dir_q      <= RESET_DIR;
         last_q     <= 1'b1;
         in_pkt_q   <= 1'b0;
         idle_cnt_q <= 8'd0;
         turn_cnt_q <= 3'd0;
      end else begin
         state_q    <= state_d;
         gnt_a_q    <= (state_d == S_OWN_A);
         gnt_b_q    <= (state_d == S_OWN_B);
         dir_q      <= dir_d;
         last_q     <= last_d;
         in_pkt_q   <= in_pkt_d;
         idle_cnt_q <= idle_cnt_d;
         turn_cnt_q <= turn_cnt_d;
      end
   end

   assign gnt_a = gnt_a_q;
   assign gnt_b = gnt_b_q;
   assign dir   = dir_q;
   assign state = state_q;

endmodule

// File: tb/tb_channel_dir_ctrl.sv
module tb_channel_dir_ctrl;

   logic clk = 1'b0;
   logic rst;
   logic req_a, valid_a, tail_a, full_a;
   logic req_b, valid_b, tail_b, full_b;
   logic gnt_a, gnt_b, xfer_a, xfer_b, dir;
   logic [1:0] state;

   int n_pass = 0;
   int n_tot  = 0;

   localparam logic [1:0] IDLE = 2'd0, OWN_A = 2'd1, OWN_B = 2'd2, TURN = 2'd3;

   typedef struct {
      string      tag;
      logic       xa;
      logic       xb;
      logic [1:0] st;
      logic       dr;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   channel_dir_ctrl #(.TURN_CYC(2), .IDLE_TO(8), .RESET_DIR(1'b0)) dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .valid_a(valid_a), .tail_a(tail_a), .full_a(full_a),
      .req_b(req_b), .valid_b(valid_b), .tail_b(tail_b), .full_b(full_b),
      .gnt_a(gnt_a), .gnt_b(gnt_b), .xfer_a(xfer_a), .xfer_b(xfer_b),
      .dir(dir), .state(state)
   );

   // in = {req_a, valid_a, tail_a, full_a, req_b, valid_b, tail_b, full_b}
   // exa/exb: xfer expected during this cycle; est/edr: state/dir after the edge.
   task automatic cyc(input string tag, input logic r, input logic [7:0] in,
                      input logic exa, input logic exb,
                      input logic [1:0] est, input logic edr);
      exp_t e;
      logic [1:0] xo, xe;
      logic [4:0] po, pe;
      e.tag = tag; e.xa = exa; e.xb = exb; e.st = est; e.dr = edr;
      sb.push_back(e);
      rst = r;
      {req_a, valid_a, tail_a, full_a, req_b, valid_b, tail_b, full_b} = in;
      #1;
      xo = {xfer_a, xfer_b};
      xe = {sb[0].xa, sb[0].xb};
      n_tot++;
      assert (xo === xe) n_pass++;
      else $error("FAIL %s xfer{a,b}: got %b expected %b", sb[0].tag, xo, xe);
      @(posedge clk);
      #1;
      e  = sb.pop_front();
      po = {state, gnt_a, gnt_b, dir};
      pe = {e.st, e.st == OWN_A, e.st == OWN_B, e.dr};
      n_tot++;
      assert (po === pe) n_pass++;
      else $error("FAIL %s {state,gnt_a,gnt_b,dir}: got %b expected %b", e.tag, po, pe);
   endtask

   initial begin
      // reset with req_a held, then granted on first edge after reset
      cyc("rst",      1'b1, 8'b1000_0000, 0, 0, IDLE,  0);
      cyc("first",    1'b0, 8'b1000_0000, 0, 0, OWN_A, 0);
      cyc("pkt1_f1",  1'b0, 8'b1100_0000, 1, 0, OWN_A, 0);
      cyc("pkt1_f2",  1'b0, 8'b1100_0000, 1, 0, OWN_A, 0);
      cyc("pkt1_f3",  1'b0, 8'b1110_0000, 1, 0, OWN_A, 0);
      cyc("drop_a",   1'b0, 8'b0000_0000, 0, 0, IDLE,  0);

      // req_b mid-packet: hold until tail, then 2-cycle TURN, then B
      cyc("a_again",  1'b0, 8'b1000_0000, 0, 0, OWN_A, 0);
      cyc("mp_f1",    1'b0, 8'b1100_0000, 1, 0, OWN_A, 0);
      cyc("mp_f2_rb", 1'b0, 8'b1100_1000, 1, 0, OWN_A, 0);
      cyc("mp_gap",   1'b0, 8'b1000_1000, 0, 0, OWN_A, 0);
      cyc("mp_tail",  1'b0, 8'b1110_1000, 1, 0, TURN,  1);
      cyc("turn1",    1'b0, 8'b0100_1100, 0, 0, TURN,  1);
      cyc("turn2",    1'b0, 8'b0000_1000, 0, 0, OWN_B, 1);
      cyc("b_pkt",    1'b0, 8'b0000_1110, 0, 1, OWN_B, 1);
      cyc("b_drop",   1'b0, 8'b0000_0000, 0, 0, IDLE,  1);

      // contention in IDLE alternates; last owner B -> A wins via TURN
      cyc("both1",    1'b0, 8'b1000_1000, 0, 0, TURN,  0);
      cyc("both1_t",  1'b0, 8'b1000_1000, 0, 0, TURN,  0);
      cyc("both1_g",  1'b0, 8'b1000_1000, 0, 0, OWN_A, 0);
      cyc("tail_rb",  1'b0, 8'b1110_1000, 1, 0, TURN,  1);
      cyc("tr_t",     1'b0, 8'b1000_1000, 0, 0, TURN,  1);
      cyc("tr_g",     1'b0, 8'b1000_1000, 0, 0, OWN_B, 1);
      cyc("idle1",    1'b0, 8'b0000_0000, 0, 0, IDLE,  1);
      cyc("both2",    1'b0, 8'b1000_1000, 0, 0, TURN,  0);
      cyc("both2_t",  1'b0, 8'b1000_1000, 0, 0, TURN,  0);
      cyc("both2_g",  1'b0, 8'b1000_1000, 0, 0, OWN_A, 0);
      cyc("idle2",    1'b0, 8'b0000_0000, 0, 0, IDLE,  0);
      cyc("both3",    1'b0, 8'b1000_1000, 0, 0, TURN,  1);
      cyc("both3_t",  1'b0, 8'b1000_1000, 0, 0, TURN,  1);
      cyc("both3_g",  1'b0, 8'b1000_1000, 0, 0, OWN_B, 1);
      cyc("idle3",    1'b0, 8'b0000_0000, 0, 0, IDLE,  1);
      cyc("b_match",  1'b0, 8'b0000_1000, 0, 0, OWN_B, 1);
      cyc("idle4",    1'b0, 8'b0000_0000, 0, 0, IDLE,  1);

      // TURN completes even though the target's request drops
      cyc("a_turn",   1'b0, 8'b1000_0000, 0, 0, TURN,  0);
      cyc("a_drop_t", 1'b0, 8'b0000_0000, 0, 0, TURN,  0);
      cyc("a_drop_g", 1'b0, 8'b0000_0000, 0, 0, OWN_A, 0);
      cyc("a_fall",   1'b0, 8'b0000_0000, 0, 0, IDLE,  0);

      // idle timeout: owner holds req_a but sends nothing
      cyc("to_grant", 1'b0, 8'b1000_0000, 0, 0, OWN_A, 0);
      for (int i = 0; i < 8; i++)
         cyc($sformatf("to_hold%0d", i), 1'b0, 8'b1000_1000, 0, 0, OWN_A, 0);
      cyc("to_fire",  1'b0, 8'b1000_1000, 0, 0, TURN,  1);
      cyc("to_t",     1'b0, 8'b1000_1000, 0, 0, TURN,  1);
      cyc("to_g",     1'b0, 8'b1000_1000, 0, 0, OWN_B, 1);

      // full receiver stalls mid-packet without releasing the channel
      cyc("b_tail_ra",1'b0, 8'b1000_1110, 0, 1, TURN,  0);
      cyc("bt_t",     1'b0, 8'b1000_0000, 0, 0, TURN,  0);
      cyc("bt_g",     1'b0, 8'b1000_0000, 0, 0, OWN_A, 0);
      cyc("st_f1",    1'b0, 8'b1100_0000, 1, 0, OWN_A, 0);
      for (int i = 0; i < 5; i++)
         cyc($sformatf("stall%0d", i), 1'b0, 8'b1110_1001, 0, 0, OWN_A, 0);
      cyc("st_tail",  1'b0, 8'b1110_1000, 1, 0, TURN,  1);

      // reset in TURN aborts at once; last_owner returns to B
      cyc("rst_turn", 1'b1, 8'b0000_1000, 0, 0, IDLE,  0);
      cyc("post_rst", 1'b0, 8'b1000_1000, 0, 0, OWN_A, 0);
      cyc("end_idle", 1'b0, 8'b0000_0000, 0, 0, IDLE,  0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
